// File: rtl/imem_pkg.sv
// Types and constants shared by the instruction-memory port arbiter and its helpers.
package imem_pkg;

  typedef enum logic [1:0] {
    OwnerNone   = 2'd0,
    OwnerFetch  = 2'd1,
    OwnerLoader = 2'd2
  } rsp_owner_e;

  localparam int unsigned IMEM_AW = 8;
  localparam logic [31:0] IMEM_OOR_DATA = 32'h0;

endpackage

// File: rtl/imem_port_arbiter_if.sv
// Bundle of fetch, loader and memory-macro signals around the arbiter.
// IMEM_ARB_LOCK_EN adds the loader lock input.
interface imem_port_arbiter_if #(
  parameter int unsigned AW = imem_pkg::IMEM_AW
) ();
  logic          f_req_valid;
  logic          f_req_ready;
  logic [31:0]   f_addr;
  logic          f_rsp_valid;
  logic [31:0]   f_rsp_data;
  logic          f_rsp_err;
  logic          l_req_valid;
  logic          l_req_ready;
  logic          l_we;
  logic [31:0]   l_addr;
  logic [31:0]   l_wdata;
  logic          l_rsp_valid;
  logic [31:0]   l_rsp_data;
  logic          l_rsp_err;
`ifdef IMEM_ARB_LOCK_EN
  logic          l_lock;
`endif
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  // Arbiter side.
  modport slave (
    input  f_req_valid, f_addr, l_req_valid, l_we, l_addr, l_wdata, mem_rdata,
`ifdef IMEM_ARB_LOCK_EN
    input  l_lock,
`endif
    output f_req_ready, f_rsp_valid, f_rsp_data, f_rsp_err,
    output l_req_ready, l_rsp_valid, l_rsp_data, l_rsp_err,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  // Requester / memory side.
  modport master (
    output f_req_valid, f_addr, l_req_valid, l_we, l_addr, l_wdata, mem_rdata,
`ifdef IMEM_ARB_LOCK_EN
    output l_lock,
`endif
    input  f_req_ready, f_rsp_valid, f_rsp_data, f_rsp_err,
    input  l_req_ready, l_rsp_valid, l_rsp_data, l_rsp_err,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/imem_range_chk.sv
// Converts a byte address to a word index and flags addresses beyond the memory depth.
module imem_range_chk
  import imem_pkg::*;
#(
  parameter int unsigned AW = IMEM_AW
) (
  input  logic [31:0]   i_addr,
  output logic [AW-1:0] o_idx,
  output logic          o_oor
);

  // Byte-lane bits are ignored: all accesses are whole words.
  logic [1:0] w_unused_lsb;
  assign w_unused_lsb = i_addr[1:0];

  assign o_idx = i_addr[AW+1:2];
  assign o_oor = (i_addr >> (AW + 2)) != 32'h0;

endmodule

// File: rtl/imem_port_arbiter.sv
// Fixed-priority arbiter (loader first) for a single-port instruction memory, with a fetch
// starvation guard. IMEM_ARB_LOCK_EN lets the loader hold the memory for burst programming.
module imem_port_arbiter
  import imem_pkg::*;
#(
  parameter int unsigned AW       = IMEM_AW,
  parameter int unsigned MAX_WAIT = 4
) (
  input logic                clk,
  input logic                rst_n,
  imem_port_arbiter_if.slave bus
);

  logic [AW-1:0] w_f_idx, w_l_idx;
  logic          w_f_oor, w_l_oor;

  imem_range_chk #(.AW(AW)) u_f_chk (.i_addr(bus.f_addr), .o_idx(w_f_idx), .o_oor(w_f_oor));
  imem_range_chk #(.AW(AW)) u_l_chk (.i_addr(bus.l_addr), .o_idx(w_l_idx), .o_oor(w_l_oor));

  rsp_owner_e r_owner, w_owner_d;
  logic       r_is_wr, w_is_wr_d;
  logic       r_err, w_err_d;
  logic [7:0] r_starve_cnt, w_starve_cnt_d;
  logic       w_force_f, w_fetch_block, w_grant_f, w_grant_l, w_mem_we;
  logic       w_rsp_f, w_rsp_l;

  assign w_force_f = r_starve_cnt == 8'(MAX_WAIT);

`ifdef IMEM_ARB_LOCK_EN
  logic r_locked, w_locked_d;
  // Held from the first locked loader grant until the cycle after l_lock drops.
  assign w_locked_d    = bus.l_lock && (r_locked || w_grant_l);
  assign w_fetch_block = r_locked;

  always_ff @(posedge clk) begin
    if (!rst_n) r_locked <= 1'b0;
    else        r_locked <= w_locked_d;
  end
`else
  assign w_fetch_block = 1'b0;
`endif

  assign w_grant_f = rst_n && bus.f_req_valid && !w_fetch_block &&
                     (!bus.l_req_valid || w_force_f);
  assign w_grant_l = rst_n && bus.l_req_valid && !w_grant_f;
  assign w_mem_we  = w_grant_l && !w_l_oor && bus.l_we;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_owner      <= OwnerNone;
      r_is_wr      <= 1'b0;
      r_err        <= 1'b0;
      r_starve_cnt <= 8'd0;
    end else begin
      r_owner      <= w_owner_d;
      r_is_wr      <= w_is_wr_d;
      r_err        <= w_err_d;
      r_starve_cnt <= w_starve_cnt_d;
    end
  end

  always_comb begin
    w_owner_d      = OwnerNone;
    w_is_wr_d      = 1'b0;
    w_err_d        = 1'b0;
    w_starve_cnt_d = r_starve_cnt;
    if (w_grant_f) begin
      w_owner_d = OwnerFetch;
      w_err_d   = w_f_oor;
    end else if (w_grant_l) begin
      w_owner_d = OwnerLoader;
      w_is_wr_d = bus.l_we;
      w_err_d   = w_l_oor;
    end
    if (!bus.f_req_valid || w_grant_f) begin
      w_starve_cnt_d = 8'd0;
    end else if (!w_force_f) begin
      w_starve_cnt_d = r_starve_cnt + 8'd1;
    end
  end

  // Gating with rst_n drops a response still in flight when reset arrives.
  assign w_rsp_f = rst_n && (r_owner == OwnerFetch);
  assign w_rsp_l = rst_n && (r_owner == OwnerLoader);

  always_comb begin
    bus.f_req_ready = w_grant_f;
    bus.l_req_ready = w_grant_l;
    bus.mem_en      = (w_grant_f && !w_f_oor) || (w_grant_l && !w_l_oor);
    bus.mem_we      = w_mem_we;
    bus.mem_addr    = w_grant_l ? w_l_idx : w_f_idx;
    bus.mem_wdata   = w_mem_we ? bus.l_wdata : 32'h0;
    bus.f_rsp_valid = w_rsp_f;
    bus.f_rsp_err   = w_rsp_f && r_err;
    bus.f_rsp_data  = (w_rsp_f && !r_err) ? bus.mem_rdata : IMEM_OOR_DATA;
    bus.l_rsp_valid = w_rsp_l;
    bus.l_rsp_err   = w_rsp_l && r_err;
    bus.l_rsp_data  = (w_rsp_l && !r_err && !r_is_wr) ? bus.mem_rdata : IMEM_OOR_DATA;
  end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Bench for imem_port_arbiter: directed table, reset/lock sequences, random traffic vs a model.
// Define IMEM_ARB_LOCK_EN for both RTL and bench to cover the loader lock.
module tb_imem_port_arbiter;
  import imem_pkg::*;

  localparam int unsigned AW       = 8;
  localparam int unsigned MAX_WAIT = 4;
  localparam int unsigned DEPTH    = 1 << AW;
  localparam int          NVEC     = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mem_init = 1'b1;
  always #5 clk = ~clk;

  imem_port_arbiter_if #(.AW(AW)) bus ();

  imem_port_arbiter #(.AW(AW), .MAX_WAIT(MAX_WAIT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [31:0] init_word(input int i);
    return 32'hA500_0000 + 32'(i);
  endfunction

  // Memory macro: synchronous, 1-cycle read latency, write at the edge.
  logic [31:0] mem [DEPTH];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= init_word(i);
    end else if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata <= mem[bus.mem_addr];
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  logic [31:0] ref_mem [DEPTH];
  int unsigned wait_cnt;
  bit          lock_held;
  bit          pf_v, pl_v, p_err;
  logic [31:0] p_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit fv, input logic [31:0] fa, input bit lv, input bit lwe,
                       input logic [31:0] la, input logic [31:0] lwd);
    bus.f_req_valid = fv;
    bus.f_addr      = fa;
    bus.l_req_valid = lv;
    bus.l_we        = lwe;
    bus.l_addr      = la;
    bus.l_wdata     = lwd;
  endtask

  // One clock: check outputs at the falling edge, advance the model, return 1ns after the rise.
  task automatic step(input bit has_exp, input bit efr, input bit elr, input bit een);
    bit fv, lv, lwe, f_oor, l_oor, gf, gl, lk, exp_en, exp_we;
    int unsigned f_idx, l_idx;
    @(negedge clk);
    fv  = bus.f_req_valid;
    lv  = bus.l_req_valid;
    lwe = bus.l_we;
`ifdef IMEM_ARB_LOCK_EN
    lk  = bus.l_lock;
`else
    lk  = 1'b0;
`endif
    if (!rst_n) begin
      check("rst_f_ready", bus.f_req_ready, 0);
      check("rst_l_ready", bus.l_req_ready, 0);
      check("rst_mem_en", bus.mem_en, 0);
      check("rst_mem_we", bus.mem_we, 0);
      check("rst_f_rsp_valid", bus.f_rsp_valid, 0);
      check("rst_f_rsp_err", bus.f_rsp_err, 0);
      check("rst_f_rsp_data", bus.f_rsp_data, 0);
      check("rst_l_rsp_valid", bus.l_rsp_valid, 0);
      check("rst_l_rsp_err", bus.l_rsp_err, 0);
      check("rst_l_rsp_data", bus.l_rsp_data, 0);
      wait_cnt  = 0;
      lock_held = 1'b0;
      pf_v      = 1'b0;
      pl_v      = 1'b0;
    end else begin
      check("f_rsp_valid", bus.f_rsp_valid, pf_v);
      check("l_rsp_valid", bus.l_rsp_valid, pl_v);
      if (pf_v) begin
        check("f_rsp_err", bus.f_rsp_err, p_err);
        check("f_rsp_data", bus.f_rsp_data, p_data);
      end
      if (pl_v) begin
        check("l_rsp_err", bus.l_rsp_err, p_err);
        check("l_rsp_data", bus.l_rsp_data, p_data);
      end
      f_oor = bus.f_addr >= 32'(4 * DEPTH);
      l_oor = bus.l_addr >= 32'(4 * DEPTH);
      f_idx = (bus.f_addr / 4) % DEPTH;
      l_idx = (bus.l_addr / 4) % DEPTH;
      if (fv && lv) gf = !lock_held && (wait_cnt >= MAX_WAIT);
      else          gf = fv && !lock_held;
      gl = lv && !gf;
      check("f_req_ready", bus.f_req_ready, gf);
      check("l_req_ready", bus.l_req_ready, gl);
      exp_en = (gf && !f_oor) || (gl && !l_oor);
      exp_we = gl && lwe && !l_oor;
      check("mem_en", bus.mem_en, exp_en);
      check("mem_we", bus.mem_we, exp_we);
      if (exp_en) check("mem_addr", bus.mem_addr, gf ? f_idx : l_idx);
      if (exp_we) check("mem_wdata", bus.mem_wdata, bus.l_wdata);
      if (has_exp) begin
        check("tbl_f_ready", bus.f_req_ready, efr);
        check("tbl_l_ready", bus.l_req_ready, elr);
        check("tbl_mem_en", bus.mem_en, een);
      end
      pf_v = gf;
      pl_v = gl;
      if (gf) begin
        p_err  = f_oor;
        p_data = f_oor ? 32'h0 : ref_mem[f_idx];
      end else if (gl) begin
        p_err  = l_oor;
        p_data = (l_oor || lwe) ? 32'h0 : ref_mem[l_idx];
        if (lwe && !l_oor) ref_mem[l_idx] = bus.l_wdata;
      end
      if (fv && !gf) wait_cnt = (wait_cnt + 1 > MAX_WAIT) ? MAX_WAIT : wait_cnt + 1;
      else           wait_cnt = 0;
      lock_held = lk && (lock_held || gl);
    end
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit          fv;
    logic [31:0] fa;
    bit          lv;
    bit          lwe;
    logic [31:0] la;
    logic [31:0] lwd;
    bit          efr, elr, een;
    bit          efv, elv, eerr;
    logic [31:0] edata;
  } vec_t;

  vec_t vecs [NVEC];

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3));
    if ($urandom_range(0, 15) == 0) a = a | (32'h1 << $urandom_range(AW + 2, 31));
    return a;
  endfunction

  initial begin
    for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = init_word(i);
    wait_cnt  = 0;
    lock_held = 1'b0;
    pf_v      = 1'b0;
    pl_v      = 1'b0;
    p_err     = 1'b0;
    p_data    = 32'h0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
`ifdef IMEM_ARB_LOCK_EN
    bus.l_lock = 1'b0;
`endif

    //           fv    fa         lv    lwe   la          lwd           efr   elr   een
    //           efv   elv   eerr  edata
    vecs[0]  = '{1'b0, 32'h0,     1'b0, 1'b0, 32'h0,      32'h0,        1'b0, 1'b0, 1'b0,
                 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, 32'h0,     1'b0, 1'b0, 32'h0,      32'h0,        1'b1, 1'b0, 1'b1,
                 1'b1, 1'b0, 1'b0, 32'hA500_0000};
    vecs[2]  = '{1'b1, 32'h4,     1'b0, 1'b0, 32'h0,      32'h0,        1'b1, 1'b0, 1'b1,
                 1'b1, 1'b0, 1'b0, 32'hA500_0001};
    vecs[3]  = '{1'b1, 32'h8,     1'b0, 1'b0, 32'h0,      32'h0,        1'b1, 1'b0, 1'b1,
                 1'b1, 1'b0, 1'b0, 32'hA500_0002};
    vecs[4]  = '{1'b0, 32'h0,     1'b1, 1'b1, 32'h10,     32'hDEADBEEF, 1'b0, 1'b1, 1'b1,
                 1'b0, 1'b1, 1'b0, 32'h0};
    vecs[5]  = '{1'b0, 32'h0,     1'b1, 1'b0, 32'h10,     32'h0,        1'b0, 1'b1, 1'b1,
                 1'b0, 1'b1, 1'b0, 32'hDEADBEEF};
    for (int i = 6; i <= 9; i++)
      vecs[i] = '{1'b1, 32'hC,    1'b1, 1'b0, 32'h20,     32'h0,        1'b0, 1'b1, 1'b1,
                  1'b0, 1'b1, 1'b0, 32'hA500_0008};
    vecs[10] = '{1'b1, 32'hC,     1'b1, 1'b0, 32'h20,     32'h0,        1'b1, 1'b0, 1'b1,
                 1'b1, 1'b0, 1'b0, 32'hA500_0003};
    vecs[11] = '{1'b1, 32'hC,     1'b1, 1'b0, 32'h20,     32'h0,        1'b0, 1'b1, 1'b1,
                 1'b0, 1'b1, 1'b0, 32'hA500_0008};
    vecs[12] = '{1'b1, 32'h400,   1'b0, 1'b0, 32'h0,      32'h0,        1'b1, 1'b0, 1'b0,
                 1'b1, 1'b0, 1'b1, 32'h0};
    vecs[13] = '{1'b0, 32'h0,     1'b1, 1'b1, 32'h1000,   32'h1234_5678, 1'b0, 1'b1, 1'b0,
                 1'b0, 1'b1, 1'b1, 32'h0};
    vecs[14] = '{1'b0, 32'h0,     1'b0, 1'b0, 32'h0,      32'h0,        1'b0, 1'b0, 1'b0,
                 1'b0, 1'b0, 1'b0, 32'h0};

    // Reset: memory preload happens during the first cycle.
    step(1'b0, 1'b0, 1'b0, 1'b0);
    mem_init = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].fv, vecs[i].fa, vecs[i].lv, vecs[i].lwe, vecs[i].la, vecs[i].lwd);
      step(1'b1, vecs[i].efr, vecs[i].elr, vecs[i].een);
      check("tbl_f_rsp_valid", bus.f_rsp_valid, vecs[i].efv);
      check("tbl_l_rsp_valid", bus.l_rsp_valid, vecs[i].elv);
      if (vecs[i].efv) begin
        check("tbl_f_rsp_err", bus.f_rsp_err, vecs[i].eerr);
        check("tbl_f_rsp_data", bus.f_rsp_data, vecs[i].edata);
      end
      if (vecs[i].elv) begin
        check("tbl_l_rsp_err", bus.l_rsp_err, vecs[i].eerr);
        check("tbl_l_rsp_data", bus.l_rsp_data, vecs[i].edata);
      end
    end

    // Reset while a fetch response is in flight: it must never appear.
    drive(1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    rst_n = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("rst_drop_f_rsp_valid", bus.f_rsp_valid, 0);

`ifdef IMEM_ARB_LOCK_EN
    // Locked 8-write burst keeps fetch out even past MAX_WAIT.
    bus.l_lock = 1'b1;
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 32'h0, 1'b1, 1'b1, 32'h40 + 32'(4 * k), $urandom);
      step(1'b1, 1'b0, 1'b1, 1'b1);
    end
    bus.l_lock = 1'b0;
    drive(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
`endif

    for (int n = 0; n < 3000; n++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      drive($urandom_range(0, 3) != 0, rand_addr(), $urandom_range(0, 1) == 1,
            $urandom_range(0, 2) == 0, rand_addr(), $urandom);
`ifdef IMEM_ARB_LOCK_EN
      if ($urandom_range(0, 7) == 0) bus.l_lock = ~bus.l_lock;
`endif
      step(1'b0, 1'b0, 1'b0, 1'b0);
    end

    rst_n = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
`ifdef IMEM_ARB_LOCK_EN
    bus.l_lock = 1'b0;
`endif
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
